// File: rtl/tube_scan.sv
// ============================================================================
// tube_scan -- scanned N-digit common-anode seven-segment driver with
//              shadow registers and an anti-ghosting dead gap per digit slot.
// Optional feature macro: LEADING_ZERO_SUPPRESS_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module tube_scan #(
  parameter int DIGITS   = 8,
  parameter int SCAN_DIV = 1000,
  parameter int GAP      = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   data_in,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  output logic [DIGITS-1:0]     digit_en,
  output logic [7:0]            segment_en,
  output logic                  frame_tick
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] C_CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] C_IDX_LAST = IW'(DIGITS - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   data_q;
  logic [DIGITS-1:0]     dp_q;
  logic [DIGITS-1:0]     blank_q;
  logic [DIGITS-1:0]     den_q, den_d;
  logic [7:0]            seg_q, seg_d;
  logic                  tick_q, tick_d;

  logic [DIGITS-1:0]     dark_mask;
  logic [3:0]            cur_nib;
  logic                  cur_dp;
  logic                  cur_dark;
  logic                  in_gap;
  logic                  slot_end;

  // Active-low hex font for segments a..g.
  function automatic logic [6:0] hex_glyph(input logic [3:0] v);
    case (v)
      4'h0: hex_glyph = 7'b0000001;
      4'h1: hex_glyph = 7'b1001111;
      4'h2: hex_glyph = 7'b0010010;
      4'h3: hex_glyph = 7'b0000110;
      4'h4: hex_glyph = 7'b1001100;
      4'h5: hex_glyph = 7'b0100100;
      4'h6: hex_glyph = 7'b0100000;
      4'h7: hex_glyph = 7'b0001111;
      4'h8: hex_glyph = 7'b0000000;
      4'h9: hex_glyph = 7'b0001100;
      4'hA: hex_glyph = 7'b0001000;
      4'hB: hex_glyph = 7'b1100000;
      4'hC: hex_glyph = 7'b1110010;
      4'hD: hex_glyph = 7'b1000010;
      4'hE: hex_glyph = 7'b0110000;
      default: hex_glyph = 7'b0111000;
    endcase
  endfunction

  always_comb begin
    dark_mask = blank_q;
`ifdef LEADING_ZERO_SUPPRESS_EN
    begin
      logic upper_zero;
      upper_zero = 1'b1;
      // Walk down from the most significant digit; digit 0 is never suppressed.
      for (int i = DIGITS - 1; i >= 1; i--) begin
        if (upper_zero && (data_q[4*i +: 4] == 4'h0) && !dp_q[i]) begin
          dark_mask[i] = 1'b1;
        end
        upper_zero = upper_zero && (data_q[4*i +: 4] == 4'h0);
      end
    end
`endif
  end

  always_comb begin
    cur_nib  = 4'h0;
    cur_dp   = 1'b0;
    cur_dark = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        cur_nib  = data_q[4*i +: 4];
        cur_dp   = dp_q[i];
        cur_dark = dark_mask[i];
      end
    end
  end

  always_comb begin
    in_gap   = (32'(cnt_q) < 32'(GAP));
    slot_end = (cnt_q == C_CNT_LAST);

    cnt_d = slot_end ? '0 : cnt_q + CW'(1);
    idx_d = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == C_IDX_LAST) ? '0 : idx_q + IW'(1);
    end

    den_d = '1;
    seg_d = 8'hFF;
    if (!in_gap && !cur_dark) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (idx_q == IW'(i)) begin
          den_d[i] = 1'b0;
        end
      end
      seg_d = {hex_glyph(cur_nib), ~cur_dp};
    end

    tick_d = slot_end && (idx_q == C_IDX_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      dp_q    <= '0;
      blank_q <= '1;
      den_q   <= '1;
      seg_q   <= 8'hFF;
      tick_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      den_q  <= den_d;
      seg_q  <= seg_d;
      tick_q <= tick_d;
      if (load) begin
        data_q  <= data_in;
        dp_q    <= dp_in;
        blank_q <= blank_in;
      end
    end
  end

  assign digit_en   = den_q;
  assign segment_en = seg_q;
  assign frame_tick = tick_q;

endmodule

`default_nettype wire

// File: tb/tb_tube_scan.sv
// ============================================================================
// tb_tube_scan -- directed table-driven bench for tube_scan (4 digits,
//                 4 cycles per slot, 1 dead cycle).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_tube_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] data_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic [3:0]  digit_en;
  logic [7:0]  segment_en;
  logic        frame_tick;

  int n_vec  = 0;
  int n_miss = 0;

  tube_scan #(.DIGITS(4), .SCAN_DIV(4), .GAP(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data_in    (data_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .digit_en   (digit_en),
    .segment_en (segment_en),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        load;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  en;
    logic [7:0]  seg;
    logic        tick;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int n, input logic r, input logic ld, input logic [15:0] d,
                     input logic [3:0] dp, input logic [3:0] bl,
                     input logic [3:0] en, input logic [7:0] seg, input logic tk);
    vec_t v;
    v.rst = r; v.load = ld; v.data = d; v.dp = dp; v.blank = bl;
    v.en = en; v.seg = seg; v.tick = tk;
    for (int k = 0; k < n; k++) vq.push_back(v);
  endtask

  task automatic check(input string name, input logic [3:0] en, input logic [7:0] seg,
                       input logic tk);
    n_vec++;
    if (digit_en !== en || segment_en !== seg || frame_tick !== tk) begin
      n_miss++;
      $display("FAIL %s: got en=%b seg=%b tick=%b, want en=%b seg=%b tick=%b",
               name, digit_en, segment_en, frame_tick, en, seg, tk);
    end
  endtask

  task automatic step(input logic r, input logic ld, input logic [15:0] d,
                      input logic [3:0] dp, input logic [3:0] bl);
    @(negedge clk);
    rst = r; load = ld; data_in = d; dp_in = dp; blank_in = bl;
    @(posedge clk);
    #1;
  endtask

  localparam logic [7:0] G0 = 8'b00000011;
  localparam logic [7:0] G1 = 8'b10011111;
  localparam logic [7:0] G2 = 8'b00100101;
  localparam logic [7:0] G3 = 8'b00001101;
  localparam logic [7:0] G4 = 8'b10011001;
  localparam logic [7:0] G5 = 8'b01001001;
  localparam logic [7:0] G8 = 8'b00000001;
  localparam logic [7:0] GA = 8'b00010001;
  localparam logic [7:0] GB_DP = 8'b11000000;
  localparam logic [7:0] GD = 8'b10000101;

  initial begin
    logic [15:0] junk;
    int first_tick;
    rst = 1'b1; load = 1'b0; data_in = '0; dp_in = '0; blank_in = '0;

    // Reset held with load high: rst wins, blank shadow ends up all ones.
    for (int k = 0; k < 3; k++) begin
      junk = 16'($urandom);
      add(1, 1, 1, junk, 4'hF, 4'h0, 4'hF, 8'hFF, 0);
    end
    add(4, 0, 0, 16'h1234, 4'h0, 4'h0, 4'hF, 8'hFF, 0);
    // Frame with 1234, starting at slot 1.
    add(1, 0, 1, 16'h1234, 4'h0, 4'h0, 4'hF, 8'hFF, 0);
    add(3, 0, 0, 16'h0, 4'h0, 4'h0, 4'b1101, G3, 0);
    add(1, 0, 0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 0);
    add(3, 0, 0, 16'h0, 4'h0, 4'h0, 4'b1011, G2, 0);
    add(1, 0, 0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 0);
    add(2, 0, 0, 16'h0, 4'h0, 4'h0, 4'b0111, G1, 0);
    add(1, 0, 0, 16'h0, 4'h0, 4'h0, 4'b0111, G1, 1);
    add(1, 0, 0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 0);
    add(3, 0, 0, 16'h0, 4'h0, 4'h0, 4'b1110, G4, 0);
    // ABCD, dp on digit 2, digit 1 blanked.
    add(1, 0, 1, 16'hABCD, 4'b0100, 4'b0010, 4'hF, 8'hFF, 0);
    add(3, 0, 0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 0);
    add(1, 0, 0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 0);
    add(3, 0, 0, 16'h0, 4'h0, 4'h0, 4'b1011, GB_DP, 0);
    add(1, 0, 0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 0);
    add(2, 0, 0, 16'h0, 4'h0, 4'h0, 4'b0111, GA, 0);
    add(1, 0, 0, 16'h0, 4'h0, 4'h0, 4'b0111, GA, 1);
    add(1, 0, 0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 0);
    // Mid-slot load of 0008: old glyph this edge, new glyph next edge.
    add(1, 0, 1, 16'h0008, 4'h0, 4'h0, 4'b1110, GD, 0);
    add(2, 0, 0, 16'h0, 4'h0, 4'h0, 4'b1110, G8, 0);
    // 0050: leading zeros.
    add(1, 0, 1, 16'h0050, 4'h0, 4'h0, 4'hF, 8'hFF, 0);
    add(3, 0, 0, 16'h0, 4'h0, 4'h0, 4'b1101, G5, 0);
    add(1, 0, 0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 0);
`ifdef LEADING_ZERO_SUPPRESS_EN
    add(3, 0, 0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 0);
    add(1, 0, 0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 0);
    add(2, 0, 0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 0);
    add(1, 0, 0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 1);
`else
    add(3, 0, 0, 16'h0, 4'h0, 4'h0, 4'b1011, G0, 0);
    add(1, 0, 0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 0);
    add(2, 0, 0, 16'h0, 4'h0, 4'h0, 4'b0111, G0, 0);
    add(1, 0, 0, 16'h0, 4'h0, 4'h0, 4'b0111, G0, 1);
`endif
    add(1, 0, 0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 0);
    add(3, 0, 0, 16'h0, 4'h0, 4'h0, 4'b1110, G0, 0);
    add(1, 0, 0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 0);
    add(3, 0, 0, 16'h0, 4'h0, 4'h0, 4'b1101, G5, 0);
    add(1, 0, 0, 16'h0, 4'h0, 4'h0, 4'hF, 8'hFF, 0);
    add(1, 0, 0, 16'h0, 4'h0, 4'h0, 4'b1011, (4'h0 == 4'h0) ?
`ifdef LEADING_ZERO_SUPPRESS_EN
        8'hFF : 8'hFF, 0);
`else
        G0 : G0, 0);
`endif

`ifdef LEADING_ZERO_SUPPRESS_EN
    vq[vq.size()-1].en = 4'hF;
`endif

    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].load, vq[i].data, vq[i].dp, vq[i].blank);
      check($sformatf("vec%0d", i), vq[i].en, vq[i].seg, vq[i].tick);
    end

    // Reset in the middle of slot 2, with load also high.
    step(1, 1, 16'h1234, 4'h0, 4'h0);
    check("midreset", 4'hF, 8'hFF, 0);
    step(0, 1, 16'h1234, 4'h0, 4'h0);
    check("restart_slot0_gap", 4'hF, 8'hFF, 0);
    step(0, 0, 16'h0, 4'h0, 4'h0);
    check("restart_slot0_glyph", 4'b1110, G4, 0);
    first_tick = 0;
    for (int e = 3; e <= 40 && first_tick == 0; e++) begin
      step(0, 0, 16'h0, 4'h0, 4'h0);
      if (frame_tick === 1'b1) first_tick = e;
    end
    n_vec++;
    if (first_tick != 16) begin
      n_miss++;
      $display("FAIL first_tick_after_reset: got edge %0d, want edge 16", first_tick);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
